// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-enable sequencer.
// ZERO_REG_MASK_EN: when defined, index 0 is hardwired and the clear sweep starts at 1.
package regfile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } seq_state_e;

  localparam int DEFAULT_ADDR_W = 5;

`ifdef ZERO_REG_MASK_EN
  localparam int FIRST_IDX = 1;
`else
  localparam int FIRST_IDX = 0;
`endif

endpackage

// File: rtl/regfile_we_sequencer_onehot_dec.sv
// Combinational binary-to-one-hot decoder, ADDR_W bits in, 2**ADDR_W enables out.
module onehot_dec #(
  parameter  int ADDR_W = 5,
  localparam int DEPTH  = 2 ** ADDR_W
) (
  input  logic [ADDR_W-1:0] bin,
  output logic [DEPTH-1:0]  onehot
);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dec
    assign onehot[gi] = (bin == ADDR_W'(gi));
  end

endmodule

// File: rtl/regfile_we_sequencer.sv
// Registered address-to-write-enable decoder with a clear-sweep state machine.
// ZERO_REG_MASK_EN: when defined, we_out[0] is never asserted and the sweep skips index 0.
module regfile_we_sequencer
  import regfile_pkg::*;
#(
  parameter  int ADDR_W         = DEFAULT_ADDR_W,
  parameter  bit SWEEP_ON_RESET = 1'b1,
  localparam int DEPTH          = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_in,
  input  logic [ADDR_W-1:0] addr,
  input  logic              clr_req,
  output logic              ready,
  output logic [DEPTH-1:0]  we_out,
  output logic [ADDR_W-1:0] sel_addr,
  output logic              zero_data,
  output logic              sweep_active,
  output logic              sweep_done
);

  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(FIRST_IDX);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DEPTH-1:0]  we_out_q, we_out_d;
  logic [ADDR_W-1:0] sel_addr_q, sel_addr_d;
  logic              zero_data_q, zero_data_d;
  logic              sweep_done_q, sweep_done_d;

  logic [ADDR_W-1:0] dec_in;
  logic [DEPTH-1:0]  dec_out;
  logic [DEPTH-1:0]  dec_eff;

  // One decoder shared between the write path and the sweep walker.
  assign dec_in = (state_q == ST_SWEEP) ? idx_q : addr;

  onehot_dec #(.ADDR_W(ADDR_W)) u_dec (
    .bin    (dec_in),
    .onehot (dec_out)
  );

`ifdef ZERO_REG_MASK_EN
  assign dec_eff = {dec_out[DEPTH-1:1], 1'b0};
`else
  assign dec_eff = dec_out;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    we_out_d     = '0;
    sel_addr_d   = sel_addr_q;
    zero_data_d  = 1'b0;
    sweep_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        we_out_d   = we_in ? dec_eff : '0;
        sel_addr_d = addr;
        if (clr_req) begin
          state_d = ST_SWEEP;
          idx_d   = FIRST;
        end
      end
      ST_SWEEP: begin
        we_out_d    = dec_eff;
        sel_addr_d  = idx_q;
        zero_data_d = 1'b1;
        // Leave at the last index instead of wrapping the counter.
        if (&idx_q) state_d = ST_DONE;
        else        idx_d   = idx_q + 1'b1;
      end
      ST_DONE: begin
        sweep_done_d = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= SWEEP_ON_RESET ? ST_SWEEP : ST_IDLE;
      idx_q        <= FIRST;
      we_out_q     <= '0;
      sel_addr_q   <= '0;
      zero_data_q  <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      we_out_q     <= we_out_d;
      sel_addr_q   <= sel_addr_d;
      zero_data_q  <= zero_data_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  assign ready        = (state_q == ST_IDLE);
  assign sweep_active = (state_q != ST_IDLE);
  assign we_out       = we_out_q;
  assign sel_addr     = sel_addr_q;
  assign zero_data    = zero_data_q;
  assign sweep_done   = sweep_done_q;

endmodule

// File: tb/tb_regfile_we_sequencer.sv
// Directed bench: default 5-bit sweep-on-reset instance plus a 3-bit idle-on-reset instance.
module tb_regfile_we_sequencer;

`ifdef ZERO_REG_MASK_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: ADDR_W=5, SWEEP_ON_RESET=1
  logic        reset, we_in, clr_req;
  logic [4:0]  addr;
  logic        ready, zero_data, sweep_active, sweep_done;
  logic [31:0] we_out;
  logic [4:0]  sel_addr;

  regfile_we_sequencer #(.ADDR_W(5), .SWEEP_ON_RESET(1'b1)) dut (
    .clk(clk), .reset(reset), .we_in(we_in), .addr(addr), .clr_req(clr_req),
    .ready(ready), .we_out(we_out), .sel_addr(sel_addr), .zero_data(zero_data),
    .sweep_active(sweep_active), .sweep_done(sweep_done)
  );

  // Instance B: ADDR_W=3, SWEEP_ON_RESET=0
  logic        b_reset, b_we_in, b_clr_req;
  logic [2:0]  b_addr;
  logic        b_ready, b_zero_data, b_sweep_active, b_sweep_done;
  logic [7:0]  b_we_out;
  logic [2:0]  b_sel_addr;

  regfile_we_sequencer #(.ADDR_W(3), .SWEEP_ON_RESET(1'b0)) dut_b (
    .clk(clk), .reset(b_reset), .we_in(b_we_in), .addr(b_addr), .clr_req(b_clr_req),
    .ready(b_ready), .we_out(b_we_out), .sel_addr(b_sel_addr), .zero_data(b_zero_data),
    .sweep_active(b_sweep_active), .sweep_done(b_sweep_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walk a full sweep on instance A from FIRST to 31, then the DONE pulse.
  task automatic check_sweep_a(input string name);
    for (int i = FIRST; i < 32; i++) begin
      tick();
      check_eq($sformatf("%s we_out[%0d]", name, i), we_out, 32'd1 << i);
      check_eq($sformatf("%s sel_addr[%0d]", name, i), {27'd0, sel_addr}, 32'(i));
      check_eq($sformatf("%s zero_data[%0d]", name, i), {31'd0, zero_data}, 32'd1);
      check_eq($sformatf("%s done_low[%0d]", name, i), {31'd0, sweep_done}, 32'd0);
      check_eq($sformatf("%s ready_low[%0d]", name, i), {31'd0, ready}, 32'd0);
    end
    tick();
    check_eq({name, " done_we_out"}, we_out, 32'd0);
    check_eq({name, " done_zero_data"}, {31'd0, zero_data}, 32'd0);
    check_eq({name, " sweep_done"}, {31'd0, sweep_done}, 32'd1);
    check_eq({name, " ready_after_done"}, {31'd0, ready}, 32'd1);
    check_eq({name, " active_after_done"}, {31'd0, sweep_active}, 32'd0);
    tick();
    check_eq({name, " sweep_done_clear"}, {31'd0, sweep_done}, 32'd0);
    check_eq({name, " ready_idle"}, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; we_in = 1'b0; clr_req = 1'b0; addr = '0;
    b_reset = 1'b1; b_we_in = 1'b0; b_clr_req = 1'b0; b_addr = '0;
    repeat (3) tick();

    // Reset state
    check_eq("rst we_out", we_out, 32'd0);
    check_eq("rst sel_addr", {27'd0, sel_addr}, 32'd0);
    check_eq("rst zero_data", {31'd0, zero_data}, 32'd0);
    check_eq("rst sweep_done", {31'd0, sweep_done}, 32'd0);
    check_eq("rst sweep_active", {31'd0, sweep_active}, 32'd1);
    check_eq("rst ready", {31'd0, ready}, 32'd0);

    // Automatic sweep after reset release
    reset = 1'b0;
    check_sweep_a("por");

    // Plain write then no write
    we_in = 1'b1; addr = 5'd13;
    tick();
    check_eq("wr13 we_out", we_out, 32'h0000_2000);
    check_eq("wr13 sel_addr", {27'd0, sel_addr}, 32'd13);
    check_eq("wr13 zero_data", {31'd0, zero_data}, 32'd0);
    we_in = 1'b0;
    tick();
    check_eq("nowr we_out", we_out, 32'd0);
    check_eq("nowr sel_addr", {27'd0, sel_addr}, 32'd13);

    // Top and bottom index writes
    we_in = 1'b1; addr = 5'd31;
    tick();
    check_eq("wr31 we_out", we_out, 32'h8000_0000);
    addr = 5'd0;
    tick();
    check_eq("wr0 we_out", we_out, (FIRST == 1) ? 32'd0 : 32'd1);
    check_eq("wr0 sel_addr", {27'd0, sel_addr}, 32'd0);

    // Write and clear request together, then writes ignored during sweep
    addr = 5'd7; clr_req = 1'b1;
    tick();
    check_eq("wr7clr we_out", we_out, 32'h0000_0080);
    check_eq("wr7clr zero_data", {31'd0, zero_data}, 32'd0);
    check_eq("wr7clr sweep_active", {31'd0, sweep_active}, 32'd1);
    check_eq("wr7clr ready", {31'd0, ready}, 32'd0);
    addr = 5'd3; clr_req = 1'b0;
    check_sweep_a("clr");
    we_in = 1'b0;

    // Reset in the middle of a sweep restarts from FIRST
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = FIRST; i <= 10; i++) tick();
    check_eq("mid we_out10", we_out, 32'h0000_0400);
    reset = 1'b1;
    tick();
    check_eq("midrst we_out", we_out, 32'd0);
    check_eq("midrst sel_addr", {27'd0, sel_addr}, 32'd0);
    check_eq("midrst zero_data", {31'd0, zero_data}, 32'd0);
    reset = 1'b0;
    check_sweep_a("restart");

    // Instance B: idle after reset, explicit clear sweep over 8 entries
    b_reset = 1'b0;
    tick();
    check_eq("b idle ready", {31'd0, b_ready}, 32'd1);
    check_eq("b idle active", {31'd0, b_sweep_active}, 32'd0);
    check_eq("b idle we_out", {24'd0, b_we_out}, 32'd0);
    b_clr_req = 1'b1;
    tick();
    b_clr_req = 1'b0;
    check_eq("b clr active", {31'd0, b_sweep_active}, 32'd1);
    for (int i = FIRST; i < 8; i++) begin
      tick();
      check_eq($sformatf("b sweep we_out[%0d]", i), {24'd0, b_we_out}, 32'd1 << i);
      check_eq($sformatf("b sweep zero_data[%0d]", i), {31'd0, b_zero_data}, 32'd1);
    end
    tick();
    check_eq("b sweep_done", {31'd0, b_sweep_done}, 32'd1);
    check_eq("b done we_out", {24'd0, b_we_out}, 32'd0);
    check_eq("b done ready", {31'd0, b_ready}, 32'd1);
    b_we_in = 1'b1; b_addr = 3'd5;
    tick();
    check_eq("b wr5 we_out", {24'd0, b_we_out}, 32'h20);
    check_eq("b wr5 sweep_done", {31'd0, b_sweep_done}, 32'd0);
    b_we_in = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
